// File: rtl/spart_pkg.sv
// Shared definitions for the SPART core: register map, parity mode and FSM states.
package spart_pkg;

   localparam logic [1:0] ADDR_DATA = 2'b00;
   localparam logic [1:0] ADDR_STAT = 2'b01;
   localparam logic [1:0] ADDR_DBL  = 2'b10;
   localparam logic [1:0] ADDR_DBH  = 2'b11;

   localparam int unsigned BAUD_W   = 16;
   localparam int unsigned TCNT_W   = 5;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_e;

endpackage

// File: rtl/spart_sync_fifo.sv
// Pointer-plus-count synchronous FIFO with registered full/empty flags.
module spart_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head_c,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_d;
   logic             push_ok;
   logic             pop_ok;

   // A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign head_c  = mem[rptr];

   always_comb begin
      count_d = count + CW'(push_ok) - CW'(pop_ok);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         if (push_ok) wptr <= wptr + AW'(1);
         if (pop_ok)  rptr <= rptr + AW'(1);
         count <= count_d;
         full  <= (count_d == CW'(DEPTH));
         empty <= (count_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= din;
   end

endmodule

// File: rtl/spart_fifo_core.sv
// Bus-mapped UART core: baud generator, TX/RX FSMs with FIFOs and register decode.
module spart_fifo_core
   import spart_pkg::*;
#(
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned PARITY      = 0,
   parameter int unsigned STOP_BITS   = 1,
   parameter logic [15:0] DEFAULT_DIV = 16'd325
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       rda,
   output logic       tbr,
   output logic       txd,
   input  logic       rxd
);

   localparam parity_e           PAR_MODE    = parity_e'(2'(PARITY));
   localparam bit                HAS_PAR     = (PAR_MODE != PAR_NONE);
   localparam logic              PAR_INV     = (PAR_MODE == PAR_ODD);
   localparam logic [TCNT_W-1:0] BIT_LAST    = TCNT_W'(15);
   localparam logic [TCNT_W-1:0] MID_LAST    = TCNT_W'(7);
   localparam logic [TCNT_W-1:0] STOP_LAST   = TCNT_W'(16 * STOP_BITS - 1);
   localparam logic [2:0]        IDX_LAST    = 3'(DATA_BITS - 1);

   logic wr, rd, tx_push, rx_pop, stat_clr, dbl_wr, dbh_wr;
   logic [BAUD_W-1:0] div, baud_cnt;
   logic tick;
   logic tx_full, tx_empty, rx_full, rx_empty;
   logic [DATA_BITS-1:0] tx_head, rx_head;
   logic rxd_m, rxd_s;
   logic perr, ferr, ovr;

   assign wr       = iocs & ~iorw;
   assign rd       = iocs & iorw;
   assign tx_push  = wr & (ioaddr == ADDR_DATA);
   assign rx_pop   = rd & (ioaddr == ADDR_DATA);
   assign stat_clr = rd & (ioaddr == ADDR_STAT);
   assign dbl_wr   = wr & (ioaddr == ADDR_DBL);
   assign dbh_wr   = wr & (ioaddr == ADDR_DBH);
   assign rda      = ~rx_empty;
   assign tbr      = ~tx_full;
   assign tick     = (baud_cnt == '0);

   // Baud down-counter; divisor writes reload it immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div      <= DEFAULT_DIV;
         baud_cnt <= DEFAULT_DIV;
      end else if (dbl_wr) begin
         div      <= {div[15:8], wdata};
         baud_cnt <= {div[15:8], wdata};
      end else if (dbh_wr) begin
         div      <= {wdata, div[7:0]};
         baud_cnt <= {wdata, div[7:0]};
      end else if (tick) begin
         baud_cnt <= div;
      end else begin
         baud_cnt <= baud_cnt - BAUD_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
      end else begin
         rxd_m <= rxd;
         rxd_s <= rxd_m;
      end
   end

   tx_state_e             tx_state, tx_state_d;
   logic [TCNT_W-1:0]     tx_cnt, tx_cnt_d;
   logic [2:0]            tx_idx, tx_idx_d;
   logic [DATA_BITS-1:0]  tx_shift, tx_shift_d;
   logic                  tx_par, tx_par_d, txd_d, tx_pop, tx_load;

   // TX next-state: IDLE and the end of STOP both start a new frame when data waits.
   always_comb begin
      tx_state_d = tx_state;
      tx_cnt_d   = tx_cnt;
      tx_idx_d   = tx_idx;
      tx_shift_d = tx_shift;
      tx_par_d   = tx_par;
      tx_pop     = 1'b0;
      tx_load    = 1'b0;
      txd_d      = 1'b1;
      if (tick) begin
         tx_cnt_d = tx_cnt + TCNT_W'(1);
         case (tx_state)
            TX_IDLE: begin
               tx_cnt_d = '0;
               tx_load  = ~tx_empty;
            end
            TX_START: if (tx_cnt == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_idx_d   = '0;
               tx_state_d = TX_DATA;
            end
            TX_DATA: if (tx_cnt == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_shift_d = tx_shift >> 1;
               tx_idx_d   = tx_idx + 3'd1;
               if (tx_idx == IDX_LAST) tx_state_d = HAS_PAR ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: if (tx_cnt == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_state_d = TX_STOP;
            end
            TX_STOP: if (tx_cnt == STOP_LAST) begin
               tx_cnt_d   = '0;
               tx_state_d = TX_IDLE;
               tx_load    = ~tx_empty;
            end
            default: tx_state_d = TX_IDLE;
         endcase
      end
      if (tx_load) begin
         tx_pop     = 1'b1;
         tx_state_d = TX_START;
         tx_shift_d = tx_head;
         tx_par_d   = (^tx_head) ^ PAR_INV;
      end
      case (tx_state_d)
         TX_START:  txd_d = 1'b0;
         TX_DATA:   txd_d = tx_shift_d[0];
         TX_PARITY: txd_d = tx_par_d;
         default:   txd_d = 1'b1;
      endcase
   end

   rx_state_e             rx_state, rx_state_d;
   logic [TCNT_W-1:0]     rx_cnt, rx_cnt_d;
   logic [2:0]            rx_idx, rx_idx_d;
   logic [DATA_BITS-1:0]  rx_shift, rx_shift_d;
   logic                  rx_pbit, rx_pbit_d, rx_push;
   logic                  set_perr, set_ferr, set_ovr;

   // RX next-state: mid-bit sampling after start qualification; stop sample decides the byte.
   always_comb begin
      rx_state_d = rx_state;
      rx_cnt_d   = rx_cnt;
      rx_idx_d   = rx_idx;
      rx_shift_d = rx_shift;
      rx_pbit_d  = rx_pbit;
      rx_push    = 1'b0;
      set_perr   = 1'b0;
      set_ferr   = 1'b0;
      set_ovr    = 1'b0;
      if (tick) begin
         rx_cnt_d = rx_cnt + TCNT_W'(1);
         case (rx_state)
            RX_IDLE: begin
               rx_cnt_d = '0;
               if (!rxd_s) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt == MID_LAST) begin
               rx_cnt_d   = '0;
               rx_idx_d   = '0;
               rx_state_d = rxd_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rxd_s, rx_shift[DATA_BITS-1:1]};
               rx_idx_d   = rx_idx + 3'd1;
               if (rx_idx == IDX_LAST) rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (rx_cnt == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_pbit_d  = rxd_s;
               rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_IDLE;
               if (!rxd_s) begin
                  set_ferr = 1'b1;
               end else if (rx_full && !rx_pop) begin
                  set_ovr = 1'b1;
               end else begin
                  rx_push  = 1'b1;
                  set_perr = HAS_PAR && (rx_pbit != ((^rx_shift) ^ PAR_INV));
               end
            end
            default: rx_state_d = RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_shift <= '0;
         tx_par   <= 1'b0;
         txd      <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_idx   <= '0;
         rx_shift <= '0;
         rx_pbit  <= 1'b0;
      end else begin
         tx_state <= tx_state_d;
         tx_cnt   <= tx_cnt_d;
         tx_idx   <= tx_idx_d;
         tx_shift <= tx_shift_d;
         tx_par   <= tx_par_d;
         txd      <= txd_d;
         rx_state <= rx_state_d;
         rx_cnt   <= rx_cnt_d;
         rx_idx   <= rx_idx_d;
         rx_shift <= rx_shift_d;
         rx_pbit  <= rx_pbit_d;
      end
   end

   // Sticky errors: a new error wins over a same-edge status-read clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perr <= 1'b0;
         ferr <= 1'b0;
         ovr  <= 1'b0;
      end else begin
         perr <= set_perr | (perr & ~stat_clr);
         ferr <= set_ferr | (ferr & ~stat_clr);
         ovr  <= set_ovr  | (ovr  & ~stat_clr);
      end
   end

   always_comb begin
      rdata = '0;
      if (rd) begin
         case (ioaddr)
            ADDR_DATA: rdata = rx_empty ? 8'h00 : 8'(rx_head);
            ADDR_STAT: rdata = {3'b000, perr, ferr, ovr, rda, tbr};
            ADDR_DBL:  rdata = div[7:0];
            default:   rdata = div[15:8];
         endcase
      end
   end

   spart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (tx_push),
      .din    (wdata[DATA_BITS-1:0]),
      .pop    (tx_pop),
      .head_c (tx_head),
      .full   (tx_full),
      .empty  (tx_empty)
   );

   spart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (rx_push),
      .din    (rx_shift),
      .pop    (rx_pop),
      .head_c (rx_head),
      .full   (rx_full),
      .empty  (rx_empty)
   );

endmodule

// File: tb/tb_spart_fifo_core.sv
// Directed/randomized bench for spart_fifo_core configured 8E1, 4-deep FIFOs, divisor 3.
module tb_spart_fifo_core;

   localparam logic [1:0] A_DATA = 2'b00;
   localparam logic [1:0] A_STAT = 2'b01;
   localparam logic [1:0] A_DBL  = 2'b10;
   localparam logic [1:0] A_DBH  = 2'b11;
   localparam int unsigned BIT_CYC   = 64;
   localparam int unsigned FRAME_CYC = 11 * BIT_CYC;

   logic       clk = 1'b0;
   logic       rst_n, iocs, iorw;
   logic [1:0] ioaddr;
   logic [7:0] wdata, rdata;
   logic       rda, tbr, txd, rxd, rxd_drv, loop;
   int unsigned cyc = 0;
   int         passed = 0;
   int         total  = 0;

   assign rxd = loop ? txd : rxd_drv;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spart_fifo_core #(
      .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1), .DEFAULT_DIV(16'd3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
      .wdata(wdata), .rdata(rdata), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
   );

   // Expected line levels of one 8E1 frame, index 0 = start bit.
   function automatic logic [10:0] frame_of(input logic [7:0] d, input bit flip, input bit bad_stop);
      logic p;
      p = (^d) ^ flip;
      return {~bad_stop, p, d, 1'b0};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      iocs = 1'b1; iorw = 1'b0; ioaddr = a; wdata = d;
      @(negedge clk);
      iocs = 1'b0; iorw = 1'b1;
   endtask

   task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      iocs = 1'b1; iorw = 1'b1; ioaddr = a;
      #1 d = rdata;
      @(negedge clk);
      iocs = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [1:0] a, input logic [7:0] exp);
      logic [7:0] r;
      cpu_read(a, r);
      check(tag, 32'(r), 32'(exp));
   endtask

   // Waits (bounded) for a start bit on txd, then samples each bit at mid-period.
   task automatic capture(output logic [10:0] bits, output int unsigned t_fall, output bit got);
      int unsigned n;
      n = 0; got = 1'b0; bits = '1; t_fall = 0;
      while (txd !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (txd === 1'b0) begin
         got = 1'b1;
         t_fall = cyc;
         repeat (BIT_CYC / 2) @(negedge clk);
         for (int i = 0; i < 11; i++) begin
            bits[i] = txd;
            if (i < 10) repeat (BIT_CYC) @(negedge clk);
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input bit flip, input bit bad_stop);
      logic [10:0] f;
      f = frame_of(d, flip, bad_stop);
      for (int i = 0; i < 11; i++) begin
         rxd_drv = f[i];
         if (i == 10 && bad_stop) begin
            repeat (48) @(negedge clk);
            rxd_drv = 1'b1;
            repeat (16) @(negedge clk);
         end else begin
            repeat (BIT_CYC) @(negedge clk);
         end
      end
      rxd_drv = 1'b1;
      repeat (16) @(negedge clk);
   endtask

   task automatic wait_rda();
      for (int i = 0; i < 200 && rda !== 1'b1; i++) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0]  bits;
      logic [7:0]   d, d2;
      logic [7:0]   q[$];
      int unsigned  t0, tf[3];
      bit           got, saw;

      rst_n = 1'b0; iocs = 1'b0; iorw = 1'b1; ioaddr = A_DATA; wdata = '0;
      rxd_drv = 1'b1; loop = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_txd", 32'(txd), 32'(1));
      check("rst_rda", 32'(rda), 32'(0));
      check("rst_tbr", 32'(tbr), 32'(1));
      check("rst_rdata", 32'(rdata), 32'(0));
      rst_n = 1'b1;
      @(negedge clk);
      read_check("rst_status", A_STAT, 8'h01);
      read_check("rst_dbl", A_DBL, 8'h03);
      read_check("rst_dbh", A_DBH, 8'h00);
      read_check("empty_read", A_DATA, 8'h00);
      cpu_write(A_DBL, 8'h2A);
      read_check("dbl_write", A_DBL, 8'h2A);
      cpu_write(A_DBL, 8'h03);

      // Loopback of 0xA5.
      loop = 1'b1;
      cpu_write(A_DATA, 8'hA5);
      t0 = cyc;
      capture(bits, tf[0], got);
      check("lb_start_seen", 32'(got), 32'(1));
      check("lb_latency_ok", 32'((tf[0] - t0) >= 1 && (tf[0] - t0) <= 5), 32'(1));
      check("lb_bits", 32'(bits), 32'(frame_of(8'hA5, 1'b0, 1'b0)));
      wait_rda();
      check("lb_rda_rise", 32'(rda), 32'(1));
      read_check("lb_data", A_DATA, 8'hA5);
      check("lb_rda_fall", 32'(rda), 32'(0));
      loop = 1'b0;

      // Back-to-back frames from three queued random bytes.
      q = {};
      cpu_write(A_DBH, 8'h01);
      for (int i = 0; i < 3; i++) begin
         d = 8'($urandom);
         q.push_back(d);
         cpu_write(A_DATA, d);
      end
      check("b2b_tbr_fill", 32'(tbr), 32'(1));
      cpu_write(A_DBH, 8'h00);
      for (int i = 0; i < 3; i++) begin
         capture(bits, tf[i], got);
         check($sformatf("b2b_frame%0d", i), 32'(bits), 32'(frame_of(q[i], 1'b0, 1'b0)));
      end
      check("b2b_gap01", 32'(tf[1] - tf[0]), 32'(FRAME_CYC));
      check("b2b_gap12", 32'(tf[2] - tf[1]), 32'(FRAME_CYC));
      check("b2b_tbr_end", 32'(tbr), 32'(1));

      // TX FIFO full while the baud tick is stalled by a large divisor.
      q = {};
      cpu_write(A_DBH, 8'h01);
      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom);
         if (q.size() < 4) q.push_back(d);
         cpu_write(A_DATA, d);
         check($sformatf("full_tbr%0d", i), 32'(tbr), 32'(q.size() < 4));
      end
      cpu_write(A_DBH, 8'h00);
      for (int i = 0; i < 4; i++) begin
         capture(bits, t0, got);
         check($sformatf("full_frame%0d", i), 32'(bits), 32'(frame_of(q[i], 1'b0, 1'b0)));
      end
      saw = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if (txd === 1'b0) saw = 1'b1;
      end
      check("full_no_extra_frame", 32'(saw), 32'(0));
      check("full_tbr_after", 32'(tbr), 32'(1));

      // Even parity: good frame then flipped-parity frame.
      d  = 8'($urandom);
      d2 = 8'($urandom);
      send_frame(d, 1'b0, 1'b0);
      read_check("par_status_ok", A_STAT, 8'h03);
      send_frame(d2, 1'b1, 1'b0);
      read_check("par_status_bad", A_STAT, 8'h13);
      read_check("par_status_clr", A_STAT, 8'h03);
      read_check("par_data0", A_DATA, d);
      read_check("par_data1", A_DATA, d2);
      check("par_rda_empty", 32'(rda), 32'(0));

      // Overrun: five frames into a 4-deep RX FIFO.
      q = {};
      for (int i = 0; i < 5; i++) begin
         d = 8'($urandom);
         if (q.size() < 4) q.push_back(d);
         send_frame(d, 1'b0, 1'b0);
      end
      read_check("ovr_status", A_STAT, 8'h07);
      for (int i = 0; i < 4; i++) read_check($sformatf("ovr_data%0d", i), A_DATA, q[i]);
      check("ovr_rda_empty", 32'(rda), 32'(0));
      read_check("ovr_empty_read", A_DATA, 8'h00);

      // Framing error: stop bit low.
      send_frame(8'($urandom), 1'b0, 1'b1);
      check("ferr_no_push", 32'(rda), 32'(0));
      read_check("ferr_status", A_STAT, 8'h09);
      read_check("ferr_status_clr", A_STAT, 8'h01);

      // Short low glitch on idle line is a false start.
      rxd_drv = 1'b0;
      repeat (20) @(negedge clk);
      rxd_drv = 1'b1;
      repeat (300) @(negedge clk);
      check("glitch_no_push", 32'(rda), 32'(0));
      read_check("glitch_status", A_STAT, 8'h01);

      // Reset mid-frame with RX data pending and a modified divisor.
      send_frame(8'($urandom), 1'b0, 1'b0);
      check("pre_reset_rda", 32'(rda), 32'(1));
      cpu_write(A_DBL, 8'h07);
      cpu_write(A_DATA, 8'($urandom));
      repeat (60) @(negedge clk);
      check("pre_reset_txd", 32'(txd), 32'(0));
      #2 rst_n = 1'b0;
      #1;
      check("reset_txd", 32'(txd), 32'(1));
      check("reset_rda", 32'(rda), 32'(0));
      check("reset_tbr", 32'(tbr), 32'(1));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      read_check("reset_dbl", A_DBL, 8'h03);
      read_check("reset_status", A_STAT, 8'h01);
      read_check("reset_rx_flushed", A_DATA, 8'h00);
      repeat (200) @(negedge clk);
      check("reset_tx_flushed", 32'(txd), 32'(1));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
